// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave holding NUM_REGS byte-strobed 32-bit read/write registers, exported flat on REG_Q.
// Write (AW/W/B) and read (AR/R) paths are independent two-state FSMs.
module axi_lite_reg_slave #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [ADDR_W-1:0]            AWADDR,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [DATA_W-1:0]            WDATA,
    input  logic [DATA_W/8-1:0]          WSTRB,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [1:0]                   BRESP,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    input  logic [ADDR_W-1:0]            ARADDR,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic [NUM_REGS*DATA_W-1:0]   REG_Q
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned IdxW  = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    wr_state_e                 wr_state_q, wr_state_d;
    rd_state_e                 rd_state_q, rd_state_d;
    logic                      ready_en_q, ready_en_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic [ADDR_W-1:0]         awaddr_q, awaddr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [StrbW-1:0]          wstrb_q, wstrb_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;

    logic              aw_hs, w_hs, ar_hs;
    logic              aw_have, w_have;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [StrbW-1:0]  wr_strb;
    logic [IdxW-1:0]   wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range;

    // State registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            regs_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ready_en_q <= ready_en_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

    // Outputs decoded from state
    always_comb begin
        AWREADY = ready_en_q && (wr_state_q == WrIdle) && !aw_held_q;
        WREADY  = ready_en_q && (wr_state_q == WrIdle) && !w_held_q;
        BVALID  = (wr_state_q == WrResp);
        BRESP   = bresp_q;
        ARREADY = ready_en_q && (rd_state_q == RdIdle);
        RVALID  = (rd_state_q == RdData);
        RDATA   = rdata_q;
        RRESP   = rresp_q;
        REG_Q   = regs_q;
    end

    // A channel accepted this cycle stands in for its not-yet-latched copy.
    always_comb begin
        aw_hs       = AWVALID && AWREADY;
        w_hs        = WVALID && WREADY;
        ar_hs       = ARVALID && ARREADY;
        aw_have     = aw_held_q || aw_hs;
        w_have      = w_held_q || w_hs;
        wr_addr     = aw_held_q ? awaddr_q : AWADDR;
        wr_data     = w_held_q ? wdata_q : WDATA;
        wr_strb     = w_held_q ? wstrb_q : WSTRB;
        wr_idx      = wr_addr[2 +: IdxW];
        rd_idx      = ARADDR[2 +: IdxW];
        wr_in_range = (wr_addr < AddrLimit);
        rd_in_range = (ARADDR < AddrLimit);
    end

    // Write path next state
    always_comb begin
        wr_state_d = wr_state_q;
        ready_en_d = 1'b1;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        unique case (wr_state_q)
            WrIdle: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (aw_have && w_have) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WrResp;
                    bresp_d    = wr_in_range ? RespOkay : RespSlvErr;
                    if (wr_in_range) begin
                        for (int b = 0; b < int'(StrbW); b++) begin
                            if (wr_strb[b]) begin
                                regs_d[int'(wr_idx) * int'(DATA_W) + b * 8 +: 8] =
                                    wr_data[b * 8 +: 8];
                            end
                        end
                    end
                end
            end
            WrResp: begin
                if (BREADY) wr_state_d = WrIdle;
            end
        endcase
    end

    // Read path next state; captures from regs_q so a same-edge write is not visible
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RdIdle: begin
                if (ar_hs) begin
                    rd_state_d = RdData;
                    rdata_d    = rd_in_range ? regs_q[int'(rd_idx) * int'(DATA_W) +: DATA_W] : '0;
                    rresp_d    = rd_in_range ? RespOkay : RespSlvErr;
                end
            end
            RdData: begin
                if (RREADY) rd_state_d = RdIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized scoreboard bench for axi_lite_reg_slave against an array-based register model.
module tb_axi_lite_reg_slave;

    localparam int NR = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [31:0]   AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]    WSTRB = '0;
    logic [1:0]    BRESP, RRESP;
    logic [31:0]   RDATA;
    logic [NR*32-1:0] REG_Q;

    axi_lite_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .REG_Q(REG_Q)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int fails  = 0;

    logic [31:0] model [NR];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int k = 0; k < NR; k++) f[k*32 +: 32] = model[k];
        return f;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        if (addr >= NR * 4) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr / 4][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        if (addr >= NR * 4) return {2'b10, 32'h0};
        return {2'b00, model[addr / 4]};
    endfunction

    // order: 0 AW+W together, 1 W first then AW after gap, 2 AW first then W after gap
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input int bdly, input bit no_b);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int idle = 0, cyc = 0;
        logic [1:0] resp;
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = (order != 1);
        WVALID  = (order != 2);
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (aw_fire) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_fire)  begin WVALID = 1'b0;  w_done = 1;  end
            if (w_done && !aw_done && !AWVALID) begin
                if (idle >= gap) AWVALID = 1'b1; else idle++;
            end
            if (aw_done && !w_done && !WVALID) begin
                if (idle >= gap) WVALID = 1'b1; else idle++;
            end
            if (++cyc > 100) begin
                flag("write_handshake_timeout");
                AWVALID = 1'b0;
                WVALID  = 1'b0;
                return;
            end
        end
        model_write(addr, data, strb, resp);
        bq.push_back(resp);
        BREADY = 1'b0;
        if (no_b) return;
        repeat (bdly) begin @(posedge ACLK); #1; end
        BREADY = 1'b1;
        cyc = 0;
        do begin @(negedge ACLK); cyc++; end while (!BVALID && cyc < 50);
        if (!BVALID) flag("bvalid_timeout");
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdly);
        int cyc = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        do begin @(negedge ACLK); cyc++; end while (!ARREADY && cyc < 50);
        if (!ARREADY) begin
            flag("arready_timeout");
            ARVALID = 1'b0;
            return;
        end
        rq.push_back(model_read(addr));
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        repeat (rdly) begin @(posedge ACLK); #1; end
        RREADY = 1'b1;
        cyc = 0;
        do begin @(negedge ACLK); cyc++; end while (!RVALID && cyc < 50);
        if (!RVALID) flag("rvalid_timeout");
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each response handshake and checks hold rules
    logic        pb_valid = 1'b0, pb_ready = 1'b0, pr_valid = 1'b0, pr_ready = 1'b0;
    logic [1:0]  pb_resp = '0, pr_resp = '0;
    logic [31:0] pr_data = '0;

    always @(negedge ACLK) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (!ARESETN) begin
            pb_valid <= 1'b0;
            pr_valid <= 1'b0;
        end else begin
            if (pb_valid && !pb_ready) begin
                check("bvalid_hold", BVALID, 1'b1);
                check("bresp_hold", BRESP, pb_resp);
            end
            if (pr_valid && !pr_ready) begin
                check("rvalid_hold", RVALID, 1'b1);
                check("rdata_hold", RDATA, pr_data);
                check("rresp_hold", RRESP, pr_resp);
            end
            if (RVALID) check("arready_in_rdata", ARREADY, 1'b0);
            if (BVALID) check("awready_wready_in_resp", {AWREADY, WREADY}, 2'b00);
            if (BVALID && BREADY) begin
                if (bq.size() == 0) flag("unexpected_bresp");
                else begin
                    eb = bq.pop_front();
                    check("bresp", BRESP, eb);
                    check("reg_q_after_write", REG_Q, model_flat());
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) flag("unexpected_rdata");
                else begin
                    er = rq.pop_front();
                    check("rdata", RDATA, er[31:0]);
                    check("rresp", RRESP, er[33:32]);
                end
            end
            pb_valid <= BVALID;
            pb_ready <= BREADY;
            pb_resp  <= BRESP;
            pr_valid <= RVALID;
            pr_ready <= RREADY;
            pr_data  <= RDATA;
            pr_resp  <= RRESP;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        for (int k = 0; k < NR; k++) model[k] = '0;

        // Reset state
        #1;
        check("reset_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("reset_valids", {BVALID, RVALID}, 2'b00);
        check("reset_resps_rdata", {BRESP, RRESP, RDATA}, 36'h0);
        check("reset_reg_q", REG_Q, '0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("awready_before_first_edge", AWREADY, 1'b0);
        @(posedge ACLK);
        #1;
        check("readys_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Reset while a response is pending
        do_write(32'h4, 32'h1234_5678, 4'hF, 0, 0, 0, 1'b1);
        check("bvalid_pending", BVALID, 1'b1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("bvalid_async_reset", BVALID, 1'b0);
        check("reg_q_async_reset", REG_Q, '0);
        bq.delete();
        for (int k = 0; k < NR; k++) model[k] = '0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        check("awready_after_rereset", AWREADY, 1'b1);

        // AW+W same cycle: response the cycle after the handshake
        AWADDR = 32'h4; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        check("same_cycle_bvalid_latency", {BVALID, BRESP}, 3'b100);
        check("same_cycle_reg1", REG_Q[63:32], 32'hDEAD_BEEF);
        model[1] = 32'hDEAD_BEEF;
        bq.push_back(2'b00);
        BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;

        // W three cycles ahead of AW, partial strobe
        do_write(32'h8, 32'hAABB_CCDD, 4'hF, 0, 0, 1, 1'b0);
        do_write(32'h8, 32'h1122_3344, 4'b0101, 1, 3, 2, 1'b0);
        check("partial_strobe_reg2", REG_Q[95:64], 32'hAA22_CC44);
        do_write(32'hC, 32'h0000_00FF, 4'h0, 2, 2, 0, 1'b0);

        // Out of range
        do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1'b0);
        do_read(32'h20, 0);

        // Read backpressure
        do_read(32'h4, 5);

        // Read collides with a write commit to the same register
        fork
            do_write(32'hC, 32'h5, 4'hF, 0, 0, 1, 1'b0);
            do_read(32'hC, 0);
        join
        do_read(32'hC, 0);

        // Randomized traffic, including misaligned and out-of-range addresses
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_write($urandom_range(0, 39), $urandom, 4'($urandom), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            else
                do_read($urandom_range(0, 39), $urandom_range(0, 3));
        end

        repeat (3) @(posedge ACLK);
        #1;
        check("bq_drained", bq.size(), 0);
        check("rq_drained", rq.size(), 0);
        check("final_reg_q", REG_Q, model_flat());

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
